mandel_fb_writer: RTL and testbench

//  Fills the 640x480 frame buffer (dual-port BRAM, port A) with Mandelbrot escape counts.
//  One pixel is computed at a time: fixed-point z = z^2 + c, one iteration per clock.

---
 rtl/mandel_fb_writer.sv | 159 +++++++++++++++
 tb/tb_mandel_fb_writer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mandel_fb_writer.sv
// Mandelbrot frame-buffer writer.
// Walks the frame in raster order and iterates z = z^2 + c in Q4.12 fixed point,
// one iteration per clock. Each escape count is written once to BRAM port A.
// c_re/c_im are stepped by accumulation, and the pixel address is stepped by
// increment, so the only multipliers are the three z products.
module mandel_fb_writer #(
  parameter int          WIDTH    = 7,
  parameter int          MAX_ITER = 127,
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter int          FRAC     = 12,
  parameter logic [15:0] X_MIN    = 16'hE000,
  parameter logic [15:0] Y_MAX    = 16'h1333,
  parameter logic [15:0] STEP     = 16'h0014
) (
  input  logic             CLK_100MHz,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             wea,
  output logic [18:0]      addra,
  output logic [WIDTH-1:0] dina
);

  localparam logic [18:0]      LAST_ADDR = 19'(H_RES * V_RES - 1);
  localparam logic [9:0]       X_LAST    = 10'(H_RES - 1);
  localparam logic [WIDTH-1:0] ITER_CAP  = WIDTH'(MAX_ITER);
  // Escape radius 2 means |z|^2 > 4, scaled by 2*FRAC fractional bits.
  localparam logic [32:0]      ESC_LIMIT = 33'd4 << (2 * FRAC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ITER   = 3'd2,
    WRITE  = 3'd3,
    DONE_S = 3'd4
  } state_t;

  state_t             state;
  logic signed [15:0] zr;
  logic signed [15:0] zi;
  logic signed [15:0] c_re;
  logic signed [15:0] c_im;
  logic [WIDTH-1:0]   iter;
  logic [9:0]         x;
  logic [8:0]         y;

  // Full-precision products. The squared magnitude is kept at 33 bits, so the
  // escape test is exact even when the wrapped z values become large.
  logic signed [31:0] zr_sq;
  logic signed [31:0] zi_sq;
  logic signed [31:0] zr_zi;
  logic [32:0]        mag;
  logic signed [32:0] re_full;
  logic signed [32:0] im_full;
  logic signed [32:0] re_sh;
  logic signed [32:0] im_sh;
  logic signed [15:0] zr_next;
  logic signed [15:0] zi_next;
  logic               escape;

  assign zr_sq   = zr * zr;
  assign zi_sq   = zi * zi;
  assign zr_zi   = zr * zi;
  assign mag     = {1'b0, zr_sq} + {1'b0, zi_sq};
  assign re_full = {zr_sq[31], zr_sq} - {zi_sq[31], zi_sq};
  assign im_full = {zr_zi, 1'b0};
  assign re_sh   = re_full >>> FRAC;
  assign im_sh   = im_full >>> FRAC;
  assign zr_next = re_sh[15:0] + c_re;
  assign zi_next = im_sh[15:0] + c_im;
  assign escape  = (mag > ESC_LIMIT) || (iter == ITER_CAP);

  // Frame sequencer: pixel walk, per-pixel iteration and registered BRAM write port.
  always_ff @(posedge CLK_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      wea   <= 1'b0;
      addra <= 19'd0;
      dina  <= '0;
      zr    <= 16'sd0;
      zi    <= 16'sd0;
      c_re  <= X_MIN;
      c_im  <= Y_MAX;
      iter  <= '0;
      x     <= 10'd0;
      y     <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          wea  <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state <= INIT;
            busy  <= 1'b1;
            addra <= 19'd0;
            x     <= 10'd0;
            y     <= 9'd0;
            c_re  <= X_MIN;
            c_im  <= Y_MAX;
          end else begin
            state <= IDLE;
          end
        end
        INIT: begin
          zr    <= 16'sd0;
          zi    <= 16'sd0;
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          if (escape) begin
            wea   <= 1'b1;
            dina  <= iter;
            state <= WRITE;
          end else begin
            zr   <= zr_next;
            zi   <= zi_next;
            iter <= iter + 1'b1;
          end
        end
        WRITE: begin
          wea <= 1'b0;
          if (addra == LAST_ADDR) begin
            state <= DONE_S;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= INIT;
            addra <= addra + 19'd1;
            if (x == X_LAST) begin
              x    <= 10'd0;
              c_re <= X_MIN;
              y    <= y + 9'd1;
              c_im <= c_im - STEP;
            end else begin
              x    <= x + 10'd1;
              c_re <= c_re + STEP;
            end
          end
        end
        DONE_S: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wea   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_fb_writer.sv
// Scoreboard bench for mandel_fb_writer.
// u_a: 3x2 frame, c_re = 0,1,2 and c_im = 0,-1 (STEP = 1.0), so the counts can be worked out by hand.
// u_b: 1x1 frame with c = -2, which sits exactly on |z|^2 == 4 and never escapes.
module tb_mandel_fb_writer;

  logic        clk;
  logic        reset_n;
  logic        start_a, start_b;
  logic        busy_a, done_a, wea_a, busy_b, done_b, wea_b;
  logic [18:0] addra_a, addra_b;
  logic [6:0]  dina_a, dina_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [25:0] exp_a[$];
  logic [25:0] exp_b[$];
  // Counts for c = 0, 1, 2, -i, 1-i, 2-i.
  int exp_cnt_a[6] = '{127, 3, 2, 127, 2, 1};

  logic prev_wea_a = 1'b0, prev_wea_b = 1'b0, gap_ok_a = 1'b0;
  int   last_a = 0, done_cnt_a = 0, done_cnt_b = 0;

  mandel_fb_writer #(.H_RES(3), .V_RES(2), .X_MIN(16'h0000), .Y_MAX(16'h0000),
                     .STEP(16'h1000)) u_a (
    .CLK_100MHz(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a),
    .done(done_a), .wea(wea_a), .addra(addra_a), .dina(dina_a));

  mandel_fb_writer #(.H_RES(1), .V_RES(1), .X_MIN(16'hE000), .Y_MAX(16'h0000)) u_b (
    .CLK_100MHz(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b),
    .done(done_b), .wea(wea_b), .addra(addra_b), .dina(dina_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for u_a: pops the scoreboard on each write and checks ordering and latency.
  always @(negedge clk) begin
    if (!reset_n && (wea_a || wea_b)) check("wea_in_reset", 1, 0);
    if (wea_a) begin
      if (prev_wea_a) check("a_wea_consecutive", 1, 0);
      if (exp_a.size() == 0) begin
        check("a_unexpected_write", 1, 0);
      end else begin
        check("a_addra", addra_a, exp_a[0][25:7]);
        check("a_dina", dina_a, exp_a[0][6:0]);
        if (gap_ok_a) check("a_pixel_latency", cyc - last_a, dina_a + 32'd3);
        void'(exp_a.pop_front());
      end
      last_a   <= cyc;
      gap_ok_a <= 1'b1;
    end else if (!busy_a) begin
      gap_ok_a <= 1'b0;
    end
    prev_wea_a <= wea_a;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  // Monitor for u_b: pops the scoreboard on each write.
  always @(negedge clk) begin
    if (wea_b) begin
      if (prev_wea_b) check("b_wea_consecutive", 1, 0);
      if (exp_b.size() == 0) begin
        check("b_unexpected_write", 1, 0);
      end else begin
        check("b_addra", addra_b, exp_b[0][25:7]);
        check("b_dina", dina_b, exp_b[0][6:0]);
        void'(exp_b.pop_front());
      end
    end
    prev_wea_b <= wea_b;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic push_frame_a();
    for (int i = 0; i < 6; i++) exp_a.push_back({19'(i), 7'(exp_cnt_a[i])});
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("a_busy_after_start", busy_a, 1);
  endtask

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (!done_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, done_a, 1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    // Reset held with the clock running; start must be ignored.
    repeat (3) @(negedge clk);
    start_a = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    check("rst_wea", wea_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_addra", addra_a, 0);
    check("rst_dina", dina_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", busy_a, 0);

    // Full 3x2 frame.
    push_frame_a();
    pulse_start_a();
    wait_done_a("a_done_frame1");
    // Start in the DONE cycle is ignored.
    check("a_busy_in_done", busy_a, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("a_start_in_done_ignored", busy_a, 0);
    check("a_queue_empty1", exp_a.size(), 0);
    check("a_done_count1", done_cnt_a, 1);

    // Mid-frame start ignored, then reset at pixel 3's write.
    push_frame_a();
    pulse_start_a();
    n = 0;
    while (exp_a.size() > 4 && n < 3000) begin @(negedge clk); n++; end
    check("a_two_writes_seen", exp_a.size(), 4);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (!(wea_a && exp_a.size() == 2) && n < 3000);
    check("a_reached_pixel3", wea_a, 1);
    reset_n = 1'b0;
    #1;
    check("a_wea_drops_on_rst", wea_a, 0);
    check("a_busy_drops_on_rst", busy_a, 0);
    check("a_addra_on_rst", addra_a, 0);
    exp_a.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // New start rewrites the whole frame from address 0.
    push_frame_a();
    pulse_start_a();
    wait_done_a("a_done_frame3");
    repeat (4) @(negedge clk);
    check("a_queue_empty3", exp_a.size(), 0);
    check("a_done_count3", done_cnt_a, 2);

    // c = -2: |z|^2 stays exactly 4, so the count saturates at 127; done follows count+4 cycles.
    exp_b.push_back({19'd0, 7'd127});
    @(negedge clk); start_b = 1'b1;
    n = 0;
    do begin
      @(negedge clk); start_b = 1'b0; n++;
    end while (!done_b && n < 1000);
    check("b_cycles_to_done", n, 131);
    @(negedge clk);
    check("b_busy_after_done", busy_b, 0);
    repeat (3) @(negedge clk);
    check("b_queue_empty", exp_b.size(), 0);
    check("b_done_count", done_cnt_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
